prog_loader: RTL and testbench

// - Writer side of the instruction-memory debug interface: the CPU and UI only read program memory; this block fills it.
// - Consumes a big-endian byte stream (valid/ready), assembles 32-bit words, emits one write per word at sequential byte addresses.
// - Holds the pipeline in reset (cpu_hold) while loading; sits between the host byte source and instr_mem's write port.

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader takes the slave modport; the host/memory side takes the master modport.
interface prog_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: turns a big-endian byte stream (16-bit word count, then words) into program-memory writes.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module prog_loader #(
    parameter int                ADDR_W    = 32,
    parameter int                MEM_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [15:0] hdr_count;
    logic        accept;
    logic        last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    // Ready depends on state alone so the host may gate valid on ready without a loop.
    assign bus.byte_ready = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                         || (state == S_CHK)
`endif
                         ;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign hdr_count = {count[15:8], bus.byte_in};
    assign last_word = (word_idx == count - 16'd1);

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked logic.
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            partial     <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= BASE_ADDR;
            bus.wr_data <= '0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state       <= S_HDR_HI;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_hold    <= 1'b1;
                        word_idx    <= '0;
                        byte_cnt    <= '0;
                        bus.wr_addr <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk         <= '0;
`endif
                    end
                end

                S_HDR_HI: begin
                    if (accept) begin
                        count <= {bus.byte_in, 8'h00};
                        state <= S_HDR_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk   <= chk ^ bus.byte_in;
`endif
                    end
                end

                S_HDR_LO: begin
                    if (accept) begin
                        count <= hdr_count;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk   <= chk ^ bus.byte_in;
`endif
                        if ({16'd0, hdr_count} > 32'(MEM_WORDS)) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (hdr_count == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= S_CHK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        partial  <= {partial[15:0], bus.byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk      <= chk ^ bus.byte_in;
`endif
                        if (byte_cnt == 2'd3) begin
                            state       <= S_WRITE;
                            bus.wr_en   <= 1'b1;
                            bus.wr_data <= {partial, bus.byte_in};
                        end
                    end
                end

                // The write strobe lasts exactly this one dead cycle; the address moves on afterwards.
                S_WRITE: begin
                    bus.wr_en   <= 1'b0;
                    word_idx    <= word_idx + 16'd1;
                    bus.wr_addr <= bus.wr_addr + ADDR_W'(4);
                    if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state    <= S_CHK;
`else
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (bus.byte_in == chk) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state     <= S_ERROR;
                    error     <= 1'b1;
                    bus.wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus random loads against a stream-level model.
// Honours PROG_LOADER_CHECKSUM_EN by appending/expecting the trailing checksum byte.
module tb_prog_loader;

    localparam int          ADDR_W    = 32;
    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W   (ADDR_W),
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bus     (bus.slave),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;

    int  tests = 0;
    int  fails = 0;
    wr_t got[$];
    int  ready_in_write = 0;
    bit  toggle = 1'b0;

    // Observed write strobes, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.wr_en) begin
            got.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            if (bus.byte_ready) ready_in_write++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xor_all(input byte_q_t s);
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    function automatic byte_q_t add_chk(input byte_q_t s);
`ifdef PROG_LOADER_CHECKSUM_EN
        s.push_back(xor_all(s));
`endif
        return s;
    endfunction

    function automatic byte_q_t make_stream(input int n);
        byte_q_t s;
        s.push_back(8'((n >> 8) & 255));
        s.push_back(8'(n & 255));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
        return s;
    endfunction

    // Reference: what a stream should produce, derived from the loader's rules with plain arithmetic.
    task automatic model(input byte_q_t s, output wr_t w[$], output bit exp_err);
        int n;
        w.delete();
        n = int'(s[0]) * 256 + int'(s[1]);
        if (n > MEM_WORDS) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = BASE_ADDR + 32'(4 * i);
            e.data = {s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]};
            w.push_back(e);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        begin
            byte_q_t prior;
            for (int i = 0; i < 2 + 4 * n; i++) prior.push_back(s[i]);
            exp_err = (s[2 + 4 * n] != xor_all(prior));
        end
`else
        exp_err = 1'b0;
`endif
    endtask

    // Offers one byte starting at a negedge; returns at a negedge once it has been taken.
    // gap_mode: 0 = always valid, 1 = valid every other cycle, 2 = random gaps.
    task automatic push_byte(input logic [7:0] b, input int gap_mode, output bit ok);
        bit hold_off;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            case (gap_mode)
                1:       hold_off = toggle;
                2:       hold_off = ($urandom_range(0, 1) == 1);
                default: hold_off = 1'b0;
            endcase
            toggle = ~toggle;
            bus.byte_in    = b;
            bus.byte_valid = !hold_off;
            ok = !hold_off && bus.byte_ready;
            @(negedge clock);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input byte_q_t s, input int gap_mode, input int start_at);
        wr_t exp_w[$];
        bit  exp_err;
        bit  ok;
        bit  all_ok;
        int  ready_before;
        int  n_cmp;

        model(s, exp_w, exp_err);
        got.delete();
        ready_before = ready_in_write;

        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_start_state"}, {61'd0, done, error, cpu_hold}, 64'b001);

        all_ok = 1'b1;
        foreach (s[i]) begin
            if (i == start_at) start = 1'b1;
            push_byte(s[i], gap_mode, ok);
            start = 1'b0;
            if (!ok) all_ok = 1'b0;
        end
        check({tag, "_bytes_taken"}, 64'(all_ok), 64'd1);

        for (int n = 0; n < 50 && !(done || error); n++) @(negedge clock);
        check({tag, "_outcome"}, {61'd0, done, error, cpu_hold},
              {61'd0, !exp_err, exp_err, exp_err});
        check({tag, "_ready_after"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_n_writes"}, 64'(got.size()), 64'(exp_w.size()));
        n_cmp = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("%s_wr%0d", tag, i), 64'(got[i]), 64'(exp_w[i]));
        end
        check({tag, "_ready_in_write"}, 64'(ready_in_write - ready_before), 64'd0);
    endtask

    initial begin
        byte_q_t ex;
        byte_q_t s;
        bit      ok;

        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        check("reset_outputs",
              {bus.byte_ready, bus.wr_en, cpu_hold, done, error},
              5'b00000);
        check("reset_addr_data", {bus.wr_addr, bus.wr_data}, {BASE_ADDR, 32'h0});
        reset = 1'b0;

        ex = add_chk('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67});

        // Directed example, then the same stream with valid toggling every other cycle
        run_load("example", ex, 0, -1);
        run_load("example_gaps", ex, 1, -1);

        // start pulsed during DATA is ignored; each run_load above/below also restarts from DONE
        run_load("start_in_data", ex, 0, 4);

        // Oversize header aborts after the second byte
        run_load("hdr_0101", '{8'h01, 8'h01}, 0, -1);

        // Empty image
        run_load("hdr_0000", add_chk('{8'h00, 8'h00}), 0, -1);
`ifdef PROG_LOADER_CHECKSUM_EN
        run_load("hdr_0000_badchk", '{8'h00, 8'h00, 8'h01}, 0, -1);
`endif

        // Reset after two data bytes, then a full reload from BASE_ADDR
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        foreach (ex[i]) begin
            if (i < 4) push_byte(ex[i], 0, ok);
        end
        reset = 1'b1;
        @(negedge clock);
        check("midload_reset_outputs",
              {bus.byte_ready, bus.wr_en, cpu_hold, done, error},
              5'b00000);
        check("midload_reset_addr_data", {bus.wr_addr, bus.wr_data}, {BASE_ADDR, 32'h0});
        reset = 1'b0;
        run_load("after_reset", ex, 0, -1);

        // Random images with random gaps
        for (int k = 0; k < 6; k++) begin
            s = add_chk(make_stream($urandom_range(1, 8)));
            run_load($sformatf("rand%0d", k), s, 2, -1);
        end

        // Capacity boundary
        s = add_chk(make_stream(MEM_WORDS));
        run_load("full_capacity", s, 0, -1);
        run_load("over_capacity", '{8'((MEM_WORDS + 1) >> 8), 8'((MEM_WORDS + 1) & 255)}, 0, -1);
        run_load("hdr_ffff", '{8'hFF, 8'hFF}, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
